// File: rtl/sif_slave_mem.sv
// sif_slave_mem: SIF target with a DEPTH x 16-bit word memory, an xa read/write
// port and a posted-write (wa) FIFO that drains into memory whenever the xa port
// is not writing. xa reads forward pending FIFO data.
// Optional feature macro: SIF_SLAVE_STATS_EN adds wr_cnt_o / rd_cnt_o counters.
module sif_slave_mem #(
   parameter int          DEPTH     = 16,
   parameter int          WA_FDEPTH = 4,
   parameter logic [15:0] BAD_DATA  = 16'hDEAD
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [15:0] xa_addr_i,
   input  logic [15:0] xa_data_wr_i,
   input  logic        xa_wr_s_i,
   input  logic        xa_rd_s_i,
   output logic [15:0] xa_data_rd_o,
   output logic        xa_rd_v_o,
   input  logic [15:0] wa_addr_i,
   input  logic [15:0] wa_data_wr_i,
   input  logic        wa_wr_s_i,
   output logic        wa_full_o,
   output logic        wa_empty_o,
   output logic        err_o,
   output logic        wa_ovf_o,
`ifdef SIF_SLAVE_STATS_EN
   input  logic        err_clr_i,
   output logic [15:0] wr_cnt_o,
   output logic [15:0] rd_cnt_o
`else
   input  logic        err_clr_i
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = $clog2(WA_FDEPTH);

   typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_STALL} state_t;

   state_t            state_q, state_d;
   logic [15:0]       mem_q [DEPTH];
   logic [AW-1:0]     fa_q  [WA_FDEPTH];
   logic [15:0]       fd_q  [WA_FDEPTH];
   logic [FW-1:0]     rptr_q, wptr_q;
   logic [FW:0]       cnt_q, cnt_d;
   logic              full_q, empty_q;
   logic [15:0]       rd_data_q, rd_data_d;
   logic              rd_v_q, rd_v_d;
   logic              err_q, err_d, ovf_q, ovf_d;

   logic              xa_oor, wa_oor;
   logic [AW-1:0]     xa_idx, wa_idx;
   logic              pop, push, err_set, ovf_set;
   logic              fwd_hit;
   logic [15:0]       fwd_data;
   logic [FW-1:0]     fidx;

   assign xa_oor = xa_addr_i >= 16'(DEPTH);
   assign wa_oor = wa_addr_i >= 16'(DEPTH);
   assign xa_idx = xa_addr_i[AW-1:0];
   assign wa_idx = wa_addr_i[AW-1:0];

   // The drain only pops while xa leaves the memory write port free; a push is
   // accepted on a full FIFO when the same edge pops an entry.
   assign pop     = (state_q == S_DRAIN) && !xa_wr_s_i && !empty_q;
   assign push    = wa_wr_s_i && !wa_oor && (!full_q || pop);
   assign ovf_set = wa_wr_s_i && full_q && !pop;
   assign err_set = (xa_wr_s_i && xa_oor) || (xa_rd_s_i && xa_oor) ||
                    (xa_wr_s_i && xa_rd_s_i) || (wa_wr_s_i && wa_oor);
   assign cnt_d   = cnt_q + (FW+1)'(push) - (FW+1)'(pop);

   // Forwarding search: walk oldest to youngest so the youngest match wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fidx     = '0;
      for (int i = 0; i < WA_FDEPTH; i++) begin
         fidx = rptr_q + FW'(i);
         if (((FW+1)'(i) < cnt_q) && (fa_q[fidx] == xa_idx)) begin
            fwd_hit  = 1'b1;
            fwd_data = fd_q[fidx];
         end
      end
   end

   // Read response and sticky error flags for the next cycle.
   always_comb begin
      rd_v_d    = xa_rd_s_i && !xa_wr_s_i;
      rd_data_d = rd_data_q;
      if (rd_v_d) begin
         if (xa_oor)       rd_data_d = BAD_DATA;
         else if (fwd_hit) rd_data_d = fwd_data;
         else              rd_data_d = mem_q[xa_idx];
      end
      err_d = err_set || (err_q && !err_clr_i);
      ovf_d = ovf_set || (ovf_q && !err_clr_i);
   end

   // Drain FSM next state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (push) state_d = S_DRAIN;
         S_DRAIN: begin
            if (xa_wr_s_i)                               state_d = S_STALL;
            else if (pop && (cnt_q == 1) && !push)       state_d = S_IDLE;
         end
         S_STALL: if (!xa_wr_s_i) state_d = S_DRAIN;
         default: state_d = S_IDLE;
      endcase
   end

   // State, memory, FIFO and flag registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         for (int i = 0; i < WA_FDEPTH; i++) begin
            fa_q[i] <= '0;
            fd_q[i] <= '0;
         end
         rptr_q    <= '0;
         wptr_q    <= '0;
         cnt_q     <= '0;
         full_q    <= 1'b0;
         empty_q   <= 1'b1;
         rd_data_q <= '0;
         rd_v_q    <= 1'b0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         if (xa_wr_s_i && !xa_oor) mem_q[xa_idx] <= xa_data_wr_i;
         if (pop) begin
            mem_q[fa_q[rptr_q]] <= fd_q[rptr_q];
            rptr_q              <= rptr_q + 1'b1;
         end
         if (push) begin
            fa_q[wptr_q] <= wa_idx;
            fd_q[wptr_q] <= wa_data_wr_i;
            wptr_q       <= wptr_q + 1'b1;
         end
         cnt_q     <= cnt_d;
         full_q    <= (cnt_d == (FW+1)'(WA_FDEPTH));
         empty_q   <= (cnt_d == '0);
         rd_data_q <= rd_data_d;
         rd_v_q    <= rd_v_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef SIF_SLAVE_STATS_EN
   logic [15:0] wr_cnt_q, rd_cnt_q;

   // Saturating statistics; an xa write and a pop never share an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (((xa_wr_s_i && !xa_oor) || pop) && (wr_cnt_q != 16'hFFFF))
            wr_cnt_q <= wr_cnt_q + 16'd1;
         if (rd_v_d && (rd_cnt_q != 16'hFFFF))
            rd_cnt_q <= rd_cnt_q + 16'd1;
      end
   end

   assign wr_cnt_o = wr_cnt_q;
   assign rd_cnt_o = rd_cnt_q;
`endif

   assign xa_data_rd_o = rd_data_q;
   assign xa_rd_v_o    = rd_v_q;
   assign wa_full_o    = full_q;
   assign wa_empty_o   = empty_q;
   assign err_o        = err_q;
   assign wa_ovf_o     = ovf_q;

endmodule
